traj_overlay_buf: RTL and testbench
===================================

# traj_overlay_buf

Trajectory overlay stage in the VGA render path, placed between the frame compositor and the display output. It keeps a circular history of the last DEPTH tracked points and paints a square marker around every stored point onto the pixel stream. It can optionally fade older points by age. New points are staged and only committed at frame boundaries, so the trajectory never tears mid-frame.

## Interface
- DEPTH, 16, number of stored points; power of two, 4..64
- HALF_W, 1, marker half-width in pixels; marker is (2*HALF_W+1) square
- COORD_W, 10, width of pixel and point coordinates
- TRAJ_COLOR, {10'd0,10'd800,10'd0}, 30-bit marker colour as {R,G,B}, 10 bits per channel
- i_clk  in  1  single clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_color  in  30  upstream pixel colour
- i_h, i_v  in  COORD_W  current pixel coordinates
- i_rendering  in  1  pixel is inside the active area
- i_pointH, i_pointV  in  COORD_W  new tracked point
- i_pointVAL  in  1  single-cycle strobe; new point valid
- i_frameStart  in  1  single-cycle strobe at frame start; commits the staged point
- i_clear  in  1  erases history and the staged point
- i_fade  in  1  1 = age-faded colour, 0 = flat TRAJ_COLOR
- o_color  out  30  output pixel colour
- o_rendering  out  1  i_rendering delayed to align with o_color
- o_count  out  $clog2(DEPTH+1)  number of valid stored points

## Operation
- Staging:
  - i_pointVAL latches (i_pointH, i_pointV) into the pending register and sets pendValid.
  - A later strobe before commit overwrites the pending point (newest wins).
- Commit:
  - On i_frameStart with pendValid=1: buf[wrPtr] <= pending; wrPtr increments mod DEPTH; o_count saturates at DEPTH; pendValid clears.
  - With pendValid=0, i_frameStart does nothing.
- Simultaneous i_pointVAL and i_frameStart: the old pending point is committed, and the new point becomes pending with pendValid=1.
- i_clear has highest priority: wrPtr=0, o_count=0, pendValid=0. Same-cycle commits and strobes are discarded. Buffer contents need not be zeroed.
- Age of entry k is (wrPtr-1-k) mod DEPTH; age 0 is the newest point. The entry is valid iff age < o_count.
- Hit for entry k: entry valid, |i_h-H_k| <= HALF_W and |i_v-V_k| <= HALF_W.
  - Differences are computed in COORD_W+1 signed bits. There is no modular wrap: pixel 1023 never hits a point at 0.
- Minimum age among hits: amin.
- Colour:
  - No hit, or delayed rendering = 0: pass delayed i_color.
  - Hit with i_fade=0: TRAJ_COLOR.
  - Hit with i_fade=1: shift = amin >> ($clog2(DEPTH)-2), range 0..3. Each 10-bit channel of TRAJ_COLOR is logically right-shifted by shift.
- i_fade is sampled together with the pixel, in pipeline stage 1.

## Timing
- Pipeline, 2 cycles:
  - Stage 1 registers hit flag, amin, fade, i_color and i_rendering.
  - Stage 2 registers o_color and o_rendering.
- Pixel sampled at cycle N appears on o_color and o_rendering at cycle N+2.
- Hit compare uses buffer state at the sampling cycle. A commit at cycle N is visible to pixels sampled at N+1 onward.
- o_count updates the cycle after the commit or clear.
- Reset (i_rst_n=0 at a clock edge): o_color=0, o_rendering=0, o_count=0, wrPtr=0, pendValid=0, all pipeline registers 0.
- Reset mid-frame flushes the pipeline. Two cycles after release, outputs reflect pass-through.
- Full throughput: one pixel per clock, no stalls, no backpressure.

## Test plan
- Reset, then drive i_rendering=1 with i_color=30'h3FF: o_count=0, o_color=0 during reset, o_color=30'h3FF two cycles after the first sample.
- Commit (100,50): pixel (101,51) gives TRAJ_COLOR at +2 cycles; pixel (102,50) and pixel (99,52) pass i_color.
- Wrap: commit 17 points at (10k,10), k=0..16. Then o_count=16, pixel (0,10) passes i_color, pixel (160,10) gives TRAJ_COLOR.
- Fade, DEPTH=16, 16 points committed:
  - Newest hit gives G=800.
  - Age 4 hit gives G=400.
  - Oldest hit (age 15) gives G=100; R and B stay 0.
- Simultaneous events:
  - Pending A with i_pointVAL(B) and i_frameStart in the same cycle: A is stored, B is committed at the next i_frameStart.
  - i_clear asserted with i_frameStart: o_count=0 and no entry written.
- Boundary: point (0,0) makes pixel (0,0) and pixel (1,1) hit. Pixel (1023,1023) does not hit. i_rendering=0 over a hit passes i_color.

Source files
------------

// File: rtl/traj_overlay_if.sv
// Pixel, point and control signals between the compositor side and the
// trajectory overlay stage.
interface traj_overlay_if #(
  parameter int COORD_W = 10,
  parameter int CNT_W   = 5
);
  logic [29:0]        i_color;
  logic [COORD_W-1:0] i_h;
  logic [COORD_W-1:0] i_v;
  logic               i_rendering;
  logic [COORD_W-1:0] i_pointH;
  logic [COORD_W-1:0] i_pointV;
  logic               i_pointVAL;
  logic               i_frameStart;
  logic               i_clear;
  logic               i_fade;
  logic [29:0]        o_color;
  logic               o_rendering;
  logic [CNT_W-1:0]   o_count;

  modport master (
    output i_color, i_h, i_v, i_rendering, i_pointH, i_pointV,
           i_pointVAL, i_frameStart, i_clear, i_fade,
    input  o_color, o_rendering, o_count
  );

  modport slave (
    input  i_color, i_h, i_v, i_rendering, i_pointH, i_pointV,
           i_pointVAL, i_frameStart, i_clear, i_fade,
    output o_color, o_rendering, o_count
  );
endinterface

// File: rtl/traj_overlay_buf.sv
// Trajectory overlay: circular history of tracked points, frame-aligned commit,
// square marker painted over the pixel stream with optional age fading.
module traj_overlay_buf #(
  parameter int          DEPTH      = 16,
  parameter int          HALF_W     = 1,
  parameter int          COORD_W    = 10,
  parameter logic [29:0] TRAJ_COLOR = {10'd0, 10'd800, 10'd0}
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  traj_overlay_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int SH_POS = PTR_W - 2;
  localparam logic signed [COORD_W:0] HW_POS = (COORD_W + 1)'(HALF_W);
  localparam logic signed [COORD_W:0] HW_NEG = -HW_POS;

  logic [COORD_W-1:0] r_buf_h [DEPTH];
  logic [COORD_W-1:0] r_buf_v [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [COORD_W-1:0] r_pend_h;
  logic [COORD_W-1:0] r_pend_v;
  logic               r_pend_valid;

  logic               r_s1_hit;
  logic [PTR_W-1:0]   r_s1_amin;
  logic               r_s1_fade;
  logic [29:0]        r_s1_color;
  logic               r_s1_rend;
  logic [29:0]        r_color;
  logic               r_rend;

  logic               w_commit;
  logic [DEPTH-1:0]   w_hit;
  logic [PTR_W-1:0]   w_age [DEPTH];
  logic [PTR_W-1:0]   w_amin;
  logic               w_any;
  logic [1:0]         w_shift;
  logic [29:0]        w_faded;
  logic [29:0]        w_mark;

  assign w_commit = bus.i_frameStart & r_pend_valid & ~bus.i_clear;

  // A strobe in the commit cycle re-arms the pending slot with the new point.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_pend_h     <= '0;
      r_pend_v     <= '0;
      r_pend_valid <= 1'b0;
    end else if (bus.i_clear) begin
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      if (w_commit) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_count != CNT_W'(DEPTH))
          r_count <= r_count + 1'b1;
      end
      if (bus.i_pointVAL) begin
        r_pend_h     <= bus.i_pointH;
        r_pend_v     <= bus.i_pointV;
        r_pend_valid <= 1'b1;
      end else if (w_commit) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_commit) begin
      r_buf_h[r_wr_ptr] <= r_pend_h;
      r_buf_v[r_wr_ptr] <= r_pend_v;
    end
  end

  // Differences use one extra sign bit so coordinates never wrap around the screen.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic signed [COORD_W:0] w_dh;
    logic signed [COORD_W:0] w_dv;
    assign w_age[gi] = r_wr_ptr - PTR_W'(gi + 1);
    assign w_dh = $signed({1'b0, bus.i_h}) - $signed({1'b0, r_buf_h[gi]});
    assign w_dv = $signed({1'b0, bus.i_v}) - $signed({1'b0, r_buf_v[gi]});
    assign w_hit[gi] = (CNT_W'(w_age[gi]) < r_count)
                     && (w_dh >= HW_NEG) && (w_dh <= HW_POS)
                     && (w_dv >= HW_NEG) && (w_dv <= HW_POS);
  end

  always_comb begin
    w_amin = '1;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_hit[k] && (w_age[k] < w_amin))
        w_amin = w_age[k];
    end
  end

  assign w_any = |w_hit;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1_hit   <= 1'b0;
      r_s1_amin  <= '0;
      r_s1_fade  <= 1'b0;
      r_s1_color <= '0;
      r_s1_rend  <= 1'b0;
    end else begin
      r_s1_hit   <= w_any;
      r_s1_amin  <= w_amin;
      r_s1_fade  <= bus.i_fade;
      r_s1_color <= bus.i_color;
      r_s1_rend  <= bus.i_rendering;
    end
  end

  // Age maps onto four brightness steps regardless of DEPTH.
  assign w_shift = 2'(r_s1_amin >> SH_POS);

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    assign w_faded[gi*10 +: 10] = TRAJ_COLOR[gi*10 +: 10] >> w_shift;
  end

  assign w_mark = r_s1_fade ? w_faded : TRAJ_COLOR;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_color <= '0;
      r_rend  <= 1'b0;
    end else begin
      r_color <= (r_s1_hit && r_s1_rend) ? w_mark : r_s1_color;
      r_rend  <= r_s1_rend;
    end
  end

  assign bus.o_color     = r_color;
  assign bus.o_rendering = r_rend;
  assign bus.o_count     = r_count;
endmodule

// File: tb/tb_traj_overlay_buf.sv
// Directed bench for traj_overlay_buf: pixel expectations queued at drive time,
// checked when the two-stage pipeline delivers them.
module tb_traj_overlay_buf;
  localparam int          COORD_W = 10;
  localparam int          CNT_W   = 5;
  localparam logic [29:0] TRAJ    = {10'd0, 10'd800, 10'd0};
  localparam logic [29:0] G400    = {10'd0, 10'd400, 10'd0};
  localparam logic [29:0] G100    = {10'd0, 10'd100, 10'd0};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  traj_overlay_if #(.COORD_W(COORD_W), .CNT_W(CNT_W)) bus ();

  traj_overlay_buf #(
    .DEPTH(16), .HALF_W(1), .COORD_W(COORD_W), .TRAJ_COLOR(TRAJ)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct {
    int          due;
    logic [29:0] color;
    logic        rend;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   cycle    = 0;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cycle++;
    while (q.size() > 0 && q[0].due <= cycle) begin
      e = q.pop_front();
      chk({e.tag, "_color"}, {2'b00, bus.o_color}, {2'b00, e.color});
      chk({e.tag, "_rend"}, {31'd0, bus.o_rendering}, {31'd0, e.rend});
      $display("pixel %s color=%h rend=%b", e.tag, bus.o_color, bus.o_rendering);
    end
  endtask

  task automatic pix(input string tag, input int h, input int v, input logic rend,
                     input logic fade, input logic [29:0] col, input logic [29:0] exp_col);
    exp_t e;
    bus.i_h         = COORD_W'(h);
    bus.i_v         = COORD_W'(v);
    bus.i_rendering = rend;
    bus.i_fade      = fade;
    bus.i_color     = col;
    e.due   = cycle + 2;
    e.color = exp_col;
    e.rend  = rend;
    e.tag   = tag;
    q.push_back(e);
    tick();
  endtask

  task automatic stage(input int h, input int v);
    bus.i_pointH   = COORD_W'(h);
    bus.i_pointV   = COORD_W'(v);
    bus.i_pointVAL = 1'b1;
    tick();
    bus.i_pointVAL = 1'b0;
  endtask

  task automatic frame();
    bus.i_frameStart = 1'b1;
    tick();
    bus.i_frameStart = 1'b0;
  endtask

  task automatic clr();
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n            = 1'b0;
    bus.i_color      = 30'h3FF;
    bus.i_h          = '0;
    bus.i_v          = '0;
    bus.i_rendering  = 1'b1;
    bus.i_pointH     = '0;
    bus.i_pointV     = '0;
    bus.i_pointVAL   = 1'b0;
    bus.i_frameStart = 1'b0;
    bus.i_clear      = 1'b0;
    bus.i_fade       = 1'b0;

    tick();
    tick();
    tick();
    chk("reset_color", {2'b00, bus.o_color}, 32'd0);
    chk("reset_rend", {31'd0, bus.o_rendering}, 32'd0);
    chk("reset_count", {27'd0, bus.o_count}, 32'd0);

    rst_n = 1'b1;
    pix("first_pass", 500, 500, 1'b1, 1'b0, 30'h3FF, 30'h3FF);

    stage(100, 50);
    frame();
    chk("count_one", {27'd0, bus.o_count}, 32'd1);
    pix("hit_101_51", 101, 51, 1'b1, 1'b0, 30'h1234567, TRAJ);
    pix("miss_102_50", 102, 50, 1'b1, 1'b0, 30'h2ABCDEF, 30'h2ABCDEF);
    pix("miss_99_52", 99, 52, 1'b1, 1'b0, 30'h0F0F0F0, 30'h0F0F0F0);

    clr();
    for (int k = 0; k <= 16; k++) begin
      stage(10 * k, 10);
      frame();
    end
    chk("count_sat", {27'd0, bus.o_count}, 32'd16);
    pix("wrap_overwritten", 0, 10, 1'b1, 1'b0, 30'h155, 30'h155);
    pix("wrap_newest", 160, 10, 1'b1, 1'b0, 30'h155, TRAJ);
    pix("fade_age0", 160, 10, 1'b1, 1'b1, 30'h0AA, TRAJ);
    pix("fade_age4", 120, 11, 1'b1, 1'b1, 30'h0AA, G400);
    pix("fade_age15", 9, 9, 1'b1, 1'b1, 30'h0AA, G100);
    pix("fade_age7", 90, 10, 1'b1, 1'b1, 30'h0AA, G400);

    clr();
    stage(300, 300);
    bus.i_pointH     = COORD_W'(400);
    bus.i_pointV     = COORD_W'(400);
    bus.i_pointVAL   = 1'b1;
    bus.i_frameStart = 1'b1;
    tick();
    bus.i_pointVAL   = 1'b0;
    bus.i_frameStart = 1'b0;
    chk("simul_count1", {27'd0, bus.o_count}, 32'd1);
    pix("simul_A_stored", 300, 300, 1'b1, 1'b0, 30'h321, TRAJ);
    pix("simul_B_pending", 400, 400, 1'b1, 1'b0, 30'h321, 30'h321);
    frame();
    chk("simul_count2", {27'd0, bus.o_count}, 32'd2);
    pix("simul_B_stored", 401, 399, 1'b1, 1'b0, 30'h321, TRAJ);

    stage(600, 600);
    bus.i_clear      = 1'b1;
    bus.i_frameStart = 1'b1;
    tick();
    bus.i_clear      = 1'b0;
    bus.i_frameStart = 1'b0;
    chk("clear_frame_count", {27'd0, bus.o_count}, 32'd0);
    frame();
    chk("clear_no_pending", {27'd0, bus.o_count}, 32'd0);
    pix("clear_C_absent", 600, 600, 1'b1, 1'b0, 30'h777, 30'h777);
    pix("clear_A_absent", 300, 300, 1'b1, 1'b0, 30'h778, 30'h778);

    stage(0, 0);
    frame();
    pix("edge_0_0", 0, 0, 1'b1, 1'b0, 30'h3FF, TRAJ);
    pix("edge_1_1", 1, 1, 1'b1, 1'b0, 30'h3FF, TRAJ);
    pix("edge_1023", 1023, 1023, 1'b1, 1'b0, 30'h3FE, 30'h3FE);
    pix("edge_2_0", 2, 0, 1'b1, 1'b0, 30'h3FD, 30'h3FD);
    pix("edge_blank", 0, 0, 1'b0, 1'b0, 30'h3FC, 30'h3FC);

    for (int k = 0; k < 4; k++) tick();
    if (q.size() != 0) chk("drain", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
